eco_xor_result_collector: RTL and testbench

- Downstream stage of the 3-bit bitwise-XOR ECO stage. Consumes its y output together with the a/b operands that produced it.
- Over a window of N accepted samples it builds a rotate-XOR signature of y and checks each y against golden a^b, counting mismatches.
- Reports signature and mismatch count through a valid/ready handshake. Serves as the sign-off checker for patched XOR stages.

---
 rtl/eco_collect_pkg.sv | 25 ++
 rtl/eco_sig_lfsr.sv | 23 ++
 rtl/eco_xor_result_collector.sv | 81 ++++++++
 tb/tb_eco_xor_result_collector.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/eco_collect_pkg.sv
// rtl/eco_collect_pkg.sv - shared state encoding, widths and rotate helper for the XOR result collector
package eco_collect_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  localparam int MAX_W = 32;
  localparam int N_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = $clog2(N_DEFAULT + 1);

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Operates on the low w bits of v (upper bits must be zero); w may be 1..MAX_W.
  function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v, input int unsigned w);
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << w) - MAX_W'(1);
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/eco_sig_lfsr.sv
// rtl/eco_sig_lfsr.sv - rotate-XOR signature register over accepted results
module eco_sig_lfsr
  import eco_collect_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] y,
  output logic [W-1:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sig <= '0;
    end else if (enable) begin
      sig <= W'(rotl1(MAX_W'(sig), W)) ^ y;
    end
  end

endmodule

// File: rtl/eco_xor_result_collector.sv
// rtl/eco_xor_result_collector.sv - windowed signature and mismatch checker for the 3-bit XOR ECO stage
module eco_xor_result_collector
  import eco_collect_pkg::*;
#(
  parameter int W      = 3,
  parameter int N      = 8,
  parameter int MCNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  input  logic [W-1:0]      y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      sig,
  output logic [MCNT_W-1:0] mism_cnt,
  output logic              busy
);

  localparam int CNT_W = cnt_width(N);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             clear;
  logic             accept;
  logic             last;

  assign accept = in_valid && (state == COLLECT);
  assign clear  = start && (state == IDLE);
  assign last   = accept && (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if (last) state_next = REPORT;
      REPORT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Mismatch counter saturates so a badly broken stage still reads as all-ones.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt      <= '0;
      mism_cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + CNT_W'(1);
      if ((y != (a ^ b)) && (mism_cnt != {MCNT_W{1'b1}})) begin
        mism_cnt <= mism_cnt + MCNT_W'(1);
      end
    end
  end

  eco_sig_lfsr #(.W(W)) u_sig (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .enable (accept),
    .y      (y),
    .sig    (sig)
  );

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == REPORT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_eco_xor_result_collector.sv
// tb/tb_eco_xor_result_collector.sv - directed self-checking bench for eco_xor_result_collector
module tb_eco_xor_result_collector;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [2:0] a, b, y;

  logic       start4, start20, start8, start1;
  logic       in_ready4, in_ready20, in_ready8, in_ready1;
  logic       out_valid4, out_valid20, out_valid8, out_valid1;
  logic       busy4, busy20, busy8, busy1;
  logic [2:0] sig4, sig20, sig8, sig1;
  logic [3:0] mism4, mism20, mism8, mism1;

  int checks = 0;
  int failures = 0;

  eco_xor_result_collector #(.W(3), .N(4), .MCNT_W(4)) u_n4 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .y(y), .out_valid(out_valid4), .out_ready(out_ready),
    .sig(sig4), .mism_cnt(mism4), .busy(busy4));

  eco_xor_result_collector #(.W(3), .N(20), .MCNT_W(4)) u_n20 (
    .clk(clk), .rst(rst), .start(start20), .in_valid(in_valid), .in_ready(in_ready20),
    .a(a), .b(b), .y(y), .out_valid(out_valid20), .out_ready(out_ready),
    .sig(sig20), .mism_cnt(mism20), .busy(busy20));

  eco_xor_result_collector #(.W(3), .N(8), .MCNT_W(4)) u_n8 (
    .clk(clk), .rst(rst), .start(start8), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a), .b(b), .y(y), .out_valid(out_valid8), .out_ready(out_ready),
    .sig(sig8), .mism_cnt(mism8), .busy(busy8));

  eco_xor_result_collector #(.W(3), .N(1), .MCNT_W(4)) u_n1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .y(y), .out_valid(out_valid1), .out_ready(out_ready),
    .sig(sig1), .mism_cnt(mism1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] aa, input logic [2:0] bb, input logic [2:0] yy);
    in_valid = v;
    a = aa;
    b = bb;
    y = yy;
  endtask

  logic [2:0] ta4 [4] = '{3'd0, 3'd3, 3'd5, 3'd6};
  logic [2:0] ty4 [4] = '{3'd1, 3'd2, 3'd4, 3'd7};
  logic [2:0] tb8 [8] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};

  initial begin
    int idx;
    int cyc;
    int extra;
    logic v;
    logic acc;

    rst = 1'b1; out_ready = 1'b0;
    start4 = 1'b0; start20 = 1'b0; start8 = 1'b0; start1 = 1'b0;
    drive(1'b0, 3'd0, 3'd0, 3'd0);
    tick();
    tick();
    check("rst_in_ready", in_ready4, 0);
    check("rst_out_valid", out_valid4, 0);
    check("rst_busy", busy4, 0);
    check("rst_sig", sig4, 0);
    check("rst_mism", mism4, 0);

    // idle with in_valid but no start: nothing moves
    rst = 1'b0;
    drive(1'b1, 3'd1, 3'd2, 3'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_in_ready", in_ready4, 0);
      check("idle_out_valid", out_valid8, 0);
      check("idle_busy", busy20, 0);
      check("idle_sig", sig4, 0);
      check("idle_mism", mism4, 0);
    end

    // basic N=4 window
    drive(1'b0, 3'd0, 3'd0, 3'd0);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("basic_busy", busy4, 1);
    check("basic_in_ready", in_ready4, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ta4[i], 3'd1, ty4[i]);
      tick();
      check("basic_out_valid_timing", out_valid4, (i == 3) ? 1 : 0);
    end
    in_valid = 1'b0;
    check("basic_sig", sig4, 6);
    check("basic_mism", mism4, 0);
    check("basic_in_ready_drop", in_ready4, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("basic_done_out_valid", out_valid4, 0);
    check("basic_done_busy", busy4, 0);
    check("basic_idle_sig_hold", sig4, 6);

    // saturation with N=20, every sample mismatched
    start20 = 1'b1;
    tick();
    start20 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'd1, 3'd1, 3'd3);
      tick();
      if (i == 14) check("sat_reach", mism20, 15);
      if (i == 16) check("sat_hold", mism20, 15);
    end
    in_valid = 1'b0;
    check("sat_out_valid", out_valid20, 1);
    check("sat_mism", mism20, 15);
    check("sat_sig", sig20, 5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("sat_done_busy", busy20, 0);

    // N=8 with ignored start after 2 accepts and random input gaps
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'(i), tb8[i], 3'(i));
      tick();
    end
    in_valid = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("ign_start_busy", busy8, 1);
    check("ign_start_in_ready", in_ready8, 1);
    check("ign_start_sig", sig8, 1);
    idx = 2;
    cyc = 0;
    while (idx < 8 && cyc < 200) begin
      v = 1'($urandom_range(0, 1));
      drive(v, 3'(idx), tb8[idx], 3'(idx));
      acc = v && in_ready8;
      tick();
      if (acc) idx++;
      cyc++;
    end
    check("bp_accepts", idx, 8);
    check("bp_out_valid", out_valid8, 1);
    drive(1'b1, 3'd0, 3'd0, 3'd7);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      check("bp_stall_valid", out_valid8, 1);
      check("bp_stall_sig", sig8, 6);
      check("bp_stall_mism", mism8, 2);
      if (in_ready8 && in_valid) extra++;
      tick();
    end
    check("bp_no_extra_accept", extra, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_done_out_valid", out_valid8, 0);
    check("bp_done_busy", busy8, 0);
    check("bp_idle_sig", sig8, 6);
    in_valid = 1'b0;

    // reset while in REPORT
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ta4[i], 3'd0, ty4[i]);
      tick();
    end
    in_valid = 1'b0;
    check("rr_pre_out_valid", out_valid4, 1);
    check("rr_pre_mism", mism4, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_out_valid", out_valid4, 0);
    check("rr_sig", sig4, 0);
    check("rr_mism", mism4, 0);
    check("rr_busy", busy4, 0);

    // N=1 boundary
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    drive(1'b1, 3'd2, 3'd7, 3'd5);
    check("n1_in_ready", in_ready1, 1);
    tick();
    in_valid = 1'b0;
    check("n1_out_valid", out_valid1, 1);
    check("n1_sig", sig1, 5);
    check("n1_mism", mism1, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("n1_done_busy", busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
